// File: rtl/counter_ctrl_if.sv
// Control/status bundle between timer registers and counter_ctrl.
// master drives the controls, slave is the timer itself.
interface counter_ctrl_if #(
  parameter int COUNT_W    = 16,
  parameter int PRESCALE_W = 8
);
  logic                  start;
  logic                  stop;
  logic                  hold;
  logic                  mode;
  logic [COUNT_W-1:0]    period;
  logic [PRESCALE_W-1:0] prescale;
  logic [COUNT_W-1:0]    count;
  logic                  busy;
  logic                  expire;
  logic                  err;

  modport master (
    output start, stop, hold, mode, period, prescale,
    input  count, busy, expire, err
  );

  modport slave (
    input  start, stop, hold, mode, period, prescale,
    output count, busy, expire, err
  );
endinterface

// File: rtl/counter_ctrl.sv
// Programmable timer: prescaled up-counter with start/stop/hold
// sequencing and one-shot or auto-reload periodic modes.
module counter_ctrl #(
  parameter int COUNT_W    = 16,
  parameter int PRESCALE_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [COUNT_W-1:0]    C_ONE = 1;
  localparam logic [PRESCALE_W-1:0] P_ONE = 1;

  state_e                state_q, state_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [COUNT_W-1:0]    period_l_q, period_l_d;
  logic [PRESCALE_W-1:0] prescale_l_q, prescale_l_d;
  logic                  mode_l_q, mode_l_d;
  logic                  expire_q, expire_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      presc_q      <= '0;
      period_l_q   <= '0;
      prescale_l_q <= '0;
      mode_l_q     <= 1'b0;
      expire_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      period_l_q   <= period_l_d;
      prescale_l_q <= prescale_l_d;
      mode_l_q     <= mode_l_d;
      expire_q     <= expire_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    presc_d      = presc_q;
    period_l_d   = period_l_q;
    prescale_l_d = prescale_l_q;
    mode_l_d     = mode_l_q;
    expire_d     = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.period == '0) begin
            err_d = 1'b1;
          end else begin
            period_l_d   = bus.period;
            prescale_l_d = bus.prescale;
            mode_l_d     = bus.mode;
            count_d      = '0;
            presc_d      = '0;
            state_d      = RUN;
          end
        end
      end
      RUN, HOLD: begin
        err_d = bus.start;
        if (bus.stop) begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (bus.hold) begin
          state_d = HOLD;
        end else begin
          // leaving HOLD ticks on the same edge, so held cycles cost exactly one clock each
          state_d = RUN;
          if (presc_q != prescale_l_q) begin
            presc_d = presc_q + P_ONE;
          end else begin
            presc_d = '0;
            if (count_q != period_l_q) begin
              count_d = count_q + C_ONE;
            end else begin
              count_d  = '0;
              expire_d = 1'b1;
              if (!mode_l_q) state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.count  = count_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.expire = expire_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random traffic,
// checked every cycle against an elapsed-time reference model.
module tb_counter_ctrl;

  logic clk;
  logic rst_n;

  counter_ctrl_if #(.COUNT_W(16), .PRESCALE_W(8)) bus ();

  counter_ctrl #(.COUNT_W(16), .PRESCALE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: active (non-held) clocks elapsed since start
  bit    m_busy;
  longint m_act;
  longint m_per;
  longint m_ps;
  bit    m_mode;
  bit    m_exp;
  bit    m_err;
  longint m_cnt;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_act  = 0;
    m_exp  = 0;
    m_err  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_edge(input bit s, input bit t, input bit h,
                            input bit m, input int p, input int ps);
    m_exp = 0;
    m_err = 0;
    if (!m_busy) begin
      if (s && !t) begin
        if (p == 0) begin
          m_err = 1;
        end else begin
          m_busy = 1;
          m_act  = 0;
          m_per  = p;
          m_ps   = ps;
          m_mode = m;
        end
      end
    end else begin
      if (s) m_err = 1;
      if (t) begin
        m_busy = 0;
        m_act  = 0;
      end else if (!h) begin
        m_act++;
        if (m_act % ((m_per + 1) * (m_ps + 1)) == 0) begin
          m_exp = 1;
          if (!m_mode) begin
            m_busy = 0;
            m_act  = 0;
          end
        end
      end
    end
    m_cnt = m_busy ? (m_act / (m_ps + 1)) % (m_per + 1) : 0;
  endtask

  task automatic cyc(input bit s, input bit t, input bit h,
                     input bit m, input int p, input int ps);
    bus.start    = s;
    bus.stop     = t;
    bus.hold     = h;
    bus.mode     = m;
    bus.period   = p[15:0];
    bus.prescale = ps[7:0];
    @(posedge clk);
    model_edge(s, t, h, m, p, ps);
    #1;
    chk("count",  bus.count,  m_cnt);
    chk("busy",   bus.busy,   m_busy);
    chk("expire", bus.expire, m_exp);
    chk("err",    bus.err,    m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 0;
    bus.stop     = 0;
    bus.hold     = 0;
    bus.mode     = 0;
    bus.period   = '0;
    bus.prescale = '0;
    model_reset();
    #1;
    chk("rst_count",  bus.count,  0);
    chk("rst_busy",   bus.busy,   0);
    chk("rst_expire", bus.expire, 0);
    chk("rst_err",    bus.err,    0);
    #99;
    rst_n = 1'b1;
    idle(2);

    // periodic, full-width period, no prescale
    cyc(1, 0, 0, 1, 16'hFFFF, 0);
    for (int i = 1; i <= 65535; i++) cyc(0, 0, 0, 1, 16'hFFFF, 0);
    chk("ff_top", bus.count, 65535);
    cyc(0, 0, 0, 1, 16'hFFFF, 0);
    chk("ff_wrap_cnt", bus.count, 0);
    chk("ff_wrap_exp", bus.expire, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 16'hFFFF, 0);
    chk("ff_cnt10", bus.count, 10);
    chk("ff_busy", bus.busy, 1);
    cyc(0, 1, 0, 0, 0, 0);
    idle(2);

    // one-shot, period 5, prescale 2
    cyc(1, 0, 0, 0, 5, 2);
    for (int i = 1; i <= 19; i++) begin
      cyc(0, 0, 0, 0, 5, 2);
      if (i == 3)  chk("os_cnt1", bus.count, 1);
      if (i == 15) chk("os_cnt5", bus.count, 5);
      if (i == 18) begin
        chk("os_exp", bus.expire, 1);
        chk("os_busy", bus.busy, 0);
        chk("os_cnt0", bus.count, 0);
      end
      if (i == 19) chk("os_exp_end", bus.expire, 0);
    end

    // hold 4 cycles at count 3, periodic period 10
    cyc(1, 0, 0, 1, 10, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, (i >= 4 && i <= 7), 1, 10, 0);
      if (i >= 3 && i <= 7) chk("hold_cnt3", bus.count, 3);
      if (i == 11) chk("hold_no_exp", bus.expire, 0);
      if (i == 15) chk("hold_exp", bus.expire, 1);
    end
    cyc(0, 1, 0, 0, 0, 0);
    idle(1);

    // illegal start with period 0
    cyc(1, 0, 0, 0, 0, 3);
    chk("p0_err", bus.err, 1);
    chk("p0_busy", bus.busy, 0);
    idle(1);
    chk("p0_err_end", bus.err, 0);

    // start while busy
    cyc(1, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 1, 5, 0);
    cyc(1, 0, 0, 1, 2, 0);
    chk("busy_err", bus.err, 1);
    chk("busy_cnt", bus.count, 2);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 2, 0);
    chk("busy_exp", bus.expire, 1);
    cyc(0, 1, 0, 0, 0, 0);

    // stop on the expiring tick
    cyc(1, 0, 0, 0, 3, 0);
    idle(3);
    cyc(0, 1, 0, 0, 3, 0);
    chk("stopx_exp", bus.expire, 0);
    chk("stopx_busy", bus.busy, 0);
    chk("stopx_cnt", bus.count, 0);

    // start + stop in IDLE
    cyc(1, 1, 0, 1, 4, 0);
    chk("ss_busy", bus.busy, 0);
    chk("ss_err", bus.err, 0);
    idle(1);

    // async reset mid-run at count 7
    cyc(1, 0, 0, 1, 20, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 20, 0);
    chk("ar_pre", bus.count, 7);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_count",  bus.count,  0);
    chk("ar_busy",   bus.busy,   0);
    chk("ar_expire", bus.expire, 0);
    chk("ar_err",    bus.err,    0);
    #10;
    rst_n = 1'b1;
    idle(5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 8) == 0, ($urandom % 32) == 0,
          ($urandom % 6) == 0, 1'($urandom % 2),
          int'($urandom % 6), int'($urandom % 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
